// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key PIO service engine: FSM states,
// PIO register offsets and the event key-index width helper.
package key_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD,
        RDW,
        CLR,
        DISP
    } state_t;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    // Width of a key index; never below one bit so a single-key build still has a port.
    function automatic int key_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is only
// accepted when a pop frees an entry in the same cycle.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full,
    output logic         drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Masking the head keeps the key output at zero while nothing is queued.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Key PIO service engine: programs the irq mask, drains edge_capture on
// each irq and turns every captured bit into a queued one-key event.
module key_event_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int               KEY_W      = 4,
    parameter logic [KEY_W-1:0] IRQ_MASK   = 4'hF,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    output logic [1:0]                  pio_address,
    output logic                        pio_chipselect,
    output logic                        pio_write_n,
    output logic [31:0]                 pio_writedata,
    input  logic [31:0]                 pio_readdata,
    input  logic                        pio_irq,
    output logic                        evt_valid,
    output logic [key_idx_w(KEY_W)-1:0] evt_key,
    input  logic                        evt_ready,
    output logic [7:0]                  drop_cnt,
    output logic                        busy
);

    localparam int IDX_W = key_idx_w(KEY_W);

    state_t           state;
    state_t           state_nxt;
    logic             armed;
    logic [KEY_W-1:0] cap;
    logic [KEY_W-1:0] cap_rest;
    logic [IDX_W-1:0] low_idx;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_drop;
    logic             unused_bits;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign cap_rest    = cap & (cap - KEY_W'(1));
    assign unused_bits = ^{pio_readdata[31:KEY_W], fifo_full};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    // INIT holds the bus quiet for the first cycle after reset, then issues the mask write.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (armed) state_nxt = IDLE;
            IDLE:    if (pio_irq && enable) state_nxt = RD;
            RD:      state_nxt = RDW;
            RDW:     state_nxt = CLR;
            CLR:     state_nxt = DISP;
            DISP:    if (cap_rest == '0) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        pio_address    = ADDR_DATA;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = 32'd0;
        busy           = 1'b1;
        push           = 1'b0;
        case (state)
            INIT: begin
                if (armed) begin
                    pio_address    = ADDR_IRQ_MASK;
                    pio_chipselect = 1'b1;
                    pio_write_n    = 1'b0;
                    pio_writedata  = 32'(IRQ_MASK);
                end
            end
            IDLE: busy = 1'b0;
            RD: begin
                pio_address    = ADDR_EDGE_CAP;
                pio_chipselect = 1'b1;
            end
            CLR: begin
                pio_address    = ADDR_EDGE_CAP;
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
            end
            DISP:    push = (cap != '0);
            default: ;
        endcase
    end

    // Lowest set bit wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        low_idx = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (cap[i]) low_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap <= '0;
        end else if (state == RDW) begin
            cap <= pio_readdata[KEY_W-1:0];
        end else if (state == DISP) begin
            cap <= cap_rest;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= 8'd0;
        end else if (fifo_drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDX_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (low_idx),
        .pop       (pop),
        .head      (evt_key),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

endmodule
